// File: rtl/fetch_if.sv
// Front-end bundle between the fetch stage and its neighbours: stall and
// redirect controls in, instruction-memory port, IF/ID register out.
interface fetch_if #(
  parameter int ADDR_W = 16
);
  // Controls from hazard_detection and EX.
  logic              PCwrite;
  logic              IF_IDwrite;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;

  // Asynchronous-read instruction memory port.
  logic [ADDR_W-1:0] imem_addr;
  logic [18:0]       imem_data;

  // IF/ID pipeline register and status.
  logic [18:0]       ID_instr;
  logic [ADDR_W-1:0] ID_pc_plus1;
  logic              ID_valid;
  logic              halted;
  logic [15:0]       fetch_count;

  // The fetch stage itself.
  modport master (
    input  PCwrite, IF_IDwrite, branch_taken, branch_target, imem_data,
    output imem_addr, ID_instr, ID_pc_plus1, ID_valid, halted, fetch_count
  );

  // Surrounding pipeline / memory / bench.
  modport slave (
    output PCwrite, IF_IDwrite, branch_taken, branch_target, imem_data,
    input  imem_addr, ID_instr, ID_pc_plus1, ID_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register. Honours hazard stalls, EX branch redirects and
// freezes permanently (until reset) once a HALT instruction leaves ID.
module fetch_stage #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]       HALT_OP  = 5'h1F
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              halted;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic [18:0]       id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_plus1_q, id_pc_plus1_d;
  logic              id_valid_q, id_valid_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic              halt_leaving_id;

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus1 = pc_q + ADDR_W'(1);

  // A valid HALT actually advances into ID/EX only when IF/ID is being
  // written and no older branch is flushing it.
  assign halt_leaving_id = (state_q == ST_RUN)
                        && id_valid_q
                        && (id_instr_q[18:14] == HALT_OP)
                        && bus.IF_IDwrite
                        && !bus.branch_taken;

  // FSM state register.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HALTED is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_leaving_id) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    halted = (state_q == ST_HALTED);
  end

  // Datapath next state, priority: halted > halting > branch > stall/normal.
  // NOTE: every target gets a hold default first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus1_d = id_pc_plus1_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;

    if (halted) begin
      // Frozen: only the valid flag is forced low.
      id_valid_d = 1'b0;
    end else if (halt_leaving_id) begin
      // HALT moves on; nothing follows it into ID.
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (bus.branch_taken) begin
      // Flush beats any load-use stall on the wrong-path instruction.
      pc_d       = bus.branch_target;
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else begin
      if (bus.PCwrite) begin
        pc_d = pc_plus1;
      end
      if (bus.IF_IDwrite) begin
        id_instr_d    = bus.imem_data;
        id_pc_plus1_d = pc_plus1;
        id_valid_d    = 1'b1;
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= '0;
      id_pc_plus1_q <= '0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus1_q <= id_pc_plus1_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.ID_instr    = id_instr_q;
  assign bus.ID_pc_plus1 = id_pc_plus1_q;
  assign bus.ID_valid    = id_valid_q;
  assign bus.halted      = halted;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 16-bit instance checked against a cycle-level
// behavioural model, plus a 4-bit instance for PC wrap and counter saturation.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(16)) bus_a ();
  fetch_if #(.ADDR_W(4))  bus_b ();

  fetch_stage #(.ADDR_W(16), .RESET_PC(16'd0), .HALT_OP(5'h1F)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a.master)
  );
  fetch_stage #(.ADDR_W(4), .RESET_PC(4'd14), .HALT_OP(5'h1F)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b.master)
  );

  // Instruction memory for the wide instance (low 8 address bits decode).
  logic [18:0] mem [256];
  assign bus_a.imem_data = mem[bus_a.imem_addr[7:0]];
  // Narrow instance reads its own address back as the instruction.
  assign bus_b.imem_data = {15'h0, bus_b.imem_addr};

  // Reference model of the wide instance's architectural state.
  logic [15:0] m_pc, m_pp1, m_count;
  logic [18:0] m_instr;
  logic        m_valid, m_halted;

  function automatic logic [18:0] tag(input int a);
    return {3'b000, 16'(a)};
  endfunction

  task automatic fill_tagged();
    for (int i = 0; i < 256; i++) mem[i] = tag(i);
  endtask

  // Drive one cycle on the wide instance and advance the model by the rules.
  task automatic tick(input logic r, input logic pcw, input logic ifw,
                      input logic br, input logic [15:0] tgt);
    logic [15:0] nxt;
    nxt = m_pc + 16'd1;
    rst_a                = r;
    bus_a.PCwrite        = pcw;
    bus_a.IF_IDwrite     = ifw;
    bus_a.branch_taken   = br;
    bus_a.branch_target  = tgt;
    if (r) begin
      m_pc = 16'd0; m_instr = '0; m_pp1 = '0; m_valid = 1'b0;
      m_count = '0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (m_valid && m_instr[18:14] == 5'h1F && ifw && !br) begin
      m_halted = 1'b1; m_instr = '0; m_valid = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_instr = '0; m_valid = 1'b0;
    end else begin
      if (ifw) begin
        m_instr = mem[m_pc[7:0]];
        m_pp1   = nxt;
        m_valid = 1'b1;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
      if (pcw) m_pc = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic r);
    rst_b = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fill_tagged();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.imem_addr !== 16'h0) begin failures++;
      $display("FAIL reset_addr got=%h exp=%h", bus_a.imem_addr, 16'h0); end
    checks++; if (bus_a.ID_instr !== 19'h0) begin failures++;
      $display("FAIL reset_instr got=%h exp=%h", bus_a.ID_instr, 19'h0); end
    checks++; if (bus_a.ID_pc_plus1 !== 16'h0) begin failures++;
      $display("FAIL reset_pp1 got=%h exp=%h", bus_a.ID_pc_plus1, 16'h0); end
    checks++; if ({bus_a.ID_valid, bus_a.halted} !== 2'b00) begin failures++;
      $display("FAIL reset_flags got=%b exp=00", {bus_a.ID_valid, bus_a.halted}); end
    checks++; if (bus_a.fetch_count !== 16'h0) begin failures++;
      $display("FAIL reset_count got=%h exp=%h", bus_a.fetch_count, 16'h0); end
  endtask

  task automatic test_free_run();
    fill_tagged();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      checks++; if (bus_a.imem_addr !== 16'(k)) begin failures++;
        $display("FAIL run_addr k=%0d got=%h exp=%h", k, bus_a.imem_addr, 16'(k)); end
      checks++; if (bus_a.ID_instr !== tag(k - 1) || bus_a.ID_valid !== 1'b1) begin failures++;
        $display("FAIL run_instr k=%0d got=%h/%b exp=%h/1", k, bus_a.ID_instr, bus_a.ID_valid, tag(k - 1)); end
      checks++; if (bus_a.ID_pc_plus1 !== 16'(k) || bus_a.fetch_count !== 16'(k)) begin failures++;
        $display("FAIL run_pp1_count k=%0d got=%h/%h exp=%h", k, bus_a.ID_pc_plus1, bus_a.fetch_count, 16'(k)); end
    end
  endtask

  task automatic test_stall();
    fill_tagged();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (5) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      checks++; if (bus_a.imem_addr !== 16'd5 || bus_a.ID_instr !== tag(4) || bus_a.ID_pc_plus1 !== 16'd5) begin failures++;
        $display("FAIL stall_hold got=%h/%h/%h exp=0005/%h/0005", bus_a.imem_addr, bus_a.ID_instr, bus_a.ID_pc_plus1, tag(4)); end
      checks++; if (bus_a.fetch_count !== 16'd5) begin failures++;
        $display("FAIL stall_count got=%h exp=%h", bus_a.fetch_count, 16'd5); end
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.imem_addr !== 16'd6 || bus_a.ID_instr !== tag(5)) begin failures++;
      $display("FAIL stall_release got=%h/%h exp=0006/%h", bus_a.imem_addr, bus_a.ID_instr, tag(5)); end
  endtask

  task automatic test_branch();
    fill_tagged();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (9) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
    checks++; if (bus_a.imem_addr !== 16'h0040 || bus_a.ID_valid !== 1'b0) begin failures++;
      $display("FAIL branch_redirect got=%h/%b exp=0040/0", bus_a.imem_addr, bus_a.ID_valid); end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.ID_instr !== tag(16'h40) || bus_a.ID_valid !== 1'b1 || bus_a.ID_pc_plus1 !== 16'h0041) begin failures++;
      $display("FAIL branch_target_in_id got=%h/%b/%h exp=%h/1/0041", bus_a.ID_instr, bus_a.ID_valid, bus_a.ID_pc_plus1, tag(16'h40)); end
  endtask

  task automatic test_halt();
    fill_tagged();
    mem[3] = {5'h1F, 14'h00AB};
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.ID_instr !== {5'h1F, 14'h00AB} || bus_a.halted !== 1'b0) begin failures++;
      $display("FAIL halt_in_id got=%h/%b exp=%h/0", bus_a.ID_instr, bus_a.halted, {5'h1F, 14'h00AB}); end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.halted !== 1'b1 || bus_a.ID_valid !== 1'b0 || bus_a.imem_addr !== 16'd4) begin failures++;
      $display("FAIL halt_assert got=%b/%b/%h exp=1/0/0004", bus_a.halted, bus_a.ID_valid, bus_a.imem_addr); end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1, 1'b1, k[0], 16'h0077);
      checks++; if (bus_a.imem_addr !== 16'd4 || bus_a.ID_valid !== 1'b0 || bus_a.halted !== 1'b1 ||
                    bus_a.fetch_count !== 16'd4 || bus_a.ID_pc_plus1 !== 16'd4) begin failures++;
        $display("FAIL halt_frozen k=%0d got=%h/%b/%b/%h/%h exp=0004/0/1/0004/0004", k, bus_a.imem_addr,
                 bus_a.ID_valid, bus_a.halted, bus_a.fetch_count, bus_a.ID_pc_plus1); end
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h0077);
    checks++; if ({bus_a.imem_addr, bus_a.ID_instr, bus_a.ID_pc_plus1, bus_a.ID_valid, bus_a.halted, bus_a.fetch_count} !== '0) begin failures++;
      $display("FAIL halt_reset got=%h/%h/%h/%b/%b/%h exp=all zero", bus_a.imem_addr, bus_a.ID_instr,
               bus_a.ID_pc_plus1, bus_a.ID_valid, bus_a.halted, bus_a.fetch_count); end
  endtask

  task automatic test_halt_blocked();
    fill_tagged();
    mem[3] = {5'h1F, 14'h0001};
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      checks++; if (bus_a.halted !== 1'b0 || bus_a.ID_instr !== {5'h1F, 14'h0001}) begin failures++;
        $display("FAIL halt_stalled got=%b/%h exp=0/%h", bus_a.halted, bus_a.ID_instr, {5'h1F, 14'h0001}); end
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.halted !== 1'b1 || bus_a.imem_addr !== 16'd4) begin failures++;
      $display("FAIL halt_after_stall got=%b/%h exp=1/0004", bus_a.halted, bus_a.imem_addr); end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 16'h0020);
    checks++; if (bus_a.halted !== 1'b0 || bus_a.imem_addr !== 16'h0020 || bus_a.ID_valid !== 1'b0) begin failures++;
      $display("FAIL halt_vs_branch got=%b/%h/%b exp=0/0020/0", bus_a.halted, bus_a.imem_addr, bus_a.ID_valid); end
    repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++; if (bus_a.halted !== 1'b0 || bus_a.ID_instr !== tag(16'h21)) begin failures++;
      $display("FAIL halt_vs_branch_run got=%b/%h exp=0/%h", bus_a.halted, bus_a.ID_instr, tag(16'h21)); end
  endtask

  task automatic test_random();
    logic r, pcw, ifw, br;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 19'($urandom);
      if (mem[i][18:14] == 5'h1F) mem[i][18] = 1'b0;
    end
    mem[8'h3C] = {5'h1F, 14'h0000};  // reachable HALT for the random walk
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 79) == 0);
      pcw = ($urandom_range(0, 3) != 0);
      ifw = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 7) == 0);
      tick(r, pcw, ifw, br, ($urandom_range(0, 3) == 0) ? 16'h003A : 16'($urandom));
      checks++;
      if (bus_a.imem_addr !== m_pc || bus_a.ID_instr !== m_instr || bus_a.ID_pc_plus1 !== m_pp1 ||
          bus_a.ID_valid !== m_valid || bus_a.halted !== m_halted || bus_a.fetch_count !== m_count) begin
        failures++;
        $display("FAIL random c=%0d got=%h/%h/%h/%b/%b/%h exp=%h/%h/%h/%b/%b/%h", c,
                 bus_a.imem_addr, bus_a.ID_instr, bus_a.ID_pc_plus1, bus_a.ID_valid, bus_a.halted, bus_a.fetch_count,
                 m_pc, m_instr, m_pp1, m_valid, m_halted, m_count);
      end
    end
  endtask

  task automatic test_wrap_and_saturate();
    tick_b(1'b1);
    checks++; if (bus_b.imem_addr !== 4'd14) begin failures++;
      $display("FAIL wrap_reset got=%h exp=e", bus_b.imem_addr); end
    tick_b(1'b0);
    checks++; if (bus_b.imem_addr !== 4'd15 || bus_b.ID_pc_plus1 !== 4'd15) begin failures++;
      $display("FAIL wrap_15 got=%h/%h exp=f/f", bus_b.imem_addr, bus_b.ID_pc_plus1); end
    tick_b(1'b0);
    checks++; if (bus_b.imem_addr !== 4'd0 || bus_b.ID_pc_plus1 !== 4'd0 || bus_b.ID_instr !== 19'd15) begin failures++;
      $display("FAIL wrap_0 got=%h/%h/%h exp=0/0/0000f", bus_b.imem_addr, bus_b.ID_pc_plus1, bus_b.ID_instr); end
    tick_b(1'b1);
    repeat (65534) tick_b(1'b0);
    checks++; if (bus_b.fetch_count !== 16'hFFFE) begin failures++;
      $display("FAIL count_fffe got=%h exp=fffe", bus_b.fetch_count); end
    tick_b(1'b0);
    checks++; if (bus_b.fetch_count !== 16'hFFFF) begin failures++;
      $display("FAIL count_ffff got=%h exp=ffff", bus_b.fetch_count); end
    repeat (3) tick_b(1'b0);
    checks++; if (bus_b.fetch_count !== 16'hFFFF) begin failures++;
      $display("FAIL count_saturate got=%h exp=ffff", bus_b.fetch_count); end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.PCwrite = 1'b1; bus_a.IF_IDwrite = 1'b1;
    bus_a.branch_taken = 1'b0; bus_a.branch_target = '0;
    bus_b.PCwrite = 1'b1; bus_b.IF_IDwrite = 1'b1;
    bus_b.branch_taken = 1'b0; bus_b.branch_target = '0;
    #2;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_halt();
    test_halt_blocked();
    test_random();
    rst_a = 1'b1;
    test_wrap_and_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 19-bit pipelined CPU: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. It sits directly upstream of ID and of `hazard_detection`, and consumes that unit's `PCwrite`/`IF_IDwrite` stall controls. It also consumes the EX-stage branch redirect (flush) and freezes the front end when a HALT instruction leaves ID.

## Interface
- `ADDR_W`, 16, PC / instruction-memory address width
- `RESET_PC`, 0, PC value loaded on reset
- `HALT_OP`, 5'h1F, opcode (instr[18:14]) that halts fetch
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `PCwrite`  in  1  from hazard_detection; 0 holds PC
- `IF_IDwrite`  in  1  from hazard_detection; 0 holds IF/ID register
- `branch_taken`  in  1  from EX; redirect PC and flush IF/ID
- `branch_target`  in  ADDR_W  redirect address, valid with `branch_taken`
- `imem_addr`  out  ADDR_W  instruction-memory address (= PC, combinational)
- `imem_data`  in  19  instruction at `imem_addr`, same-cycle (asynchronous read)
- `ID_instr`  out  19  IF/ID instruction
- `ID_pc_plus1`  out  ADDR_W  PC+1 of the instruction in IF/ID
- `ID_valid`  out  1  IF/ID holds a real instruction (0 = bubble)
- `halted`  out  1  fetch frozen by HALT
- `fetch_count`  out  16  instructions loaded into IF/ID since reset, saturating

## Operation
- State machine: RUN, HALTED. Reset → RUN. RUN → HALTED when `ID_valid`=1, `ID_instr[18:14]`=HALT_OP, `IF_IDwrite`=1, and `branch_taken`=0. HALTED exits only on `rst`.
- Per-edge priority, highest first: rst > HALTED > branch_taken > stall controls > normal.
- rst: PC←RESET_PC, ID_instr←0, ID_pc_plus1←0, ID_valid←0, fetch_count←0, state←RUN.
- HALTED: PC, ID_instr, ID_pc_plus1, fetch_count hold; ID_valid←0. `PCwrite`, `IF_IDwrite`, and `branch_taken` are ignored.
- RUN entering HALTED: PC holds; IF/ID ← bubble (ID_instr←0, ID_valid←0), so the HALT instruction moves on into ID/EX and no later instruction follows it.
- branch_taken=1 (RUN): PC←branch_target; IF/ID ← bubble. This applies regardless of `PCwrite`/`IF_IDwrite`, because a flush overrides a load-use stall on a wrong-path instruction.
- Normal (RUN, no branch):
  - PCwrite=1 → PC←PC+1; PCwrite=0 → PC holds.
  - IF_IDwrite=1 → ID_instr←imem_data, ID_pc_plus1←PC+1, ID_valid←1. IF_IDwrite=0 → all IF/ID fields hold.
  - The two enables are applied independently.
- PC+1 is computed modulo 2^ADDR_W, so PC at all-ones wraps to 0.
- fetch_count increments on each edge where ID_valid is written to 1 with new data. It saturates at 16'hFFFF.

## Timing
- Reset values: imem_addr=RESET_PC, ID_instr=0, ID_pc_plus1=0, ID_valid=0, halted=0, fetch_count=0.
- Fetch latency: the instruction at address A is presented at imem_addr in cycle t and appears at ID_instr in cycle t+1.
- Stall: with PCwrite=IF_IDwrite=0 in cycle t, imem_addr, ID_instr, and ID_valid in t+1 equal their values in t.
- Redirect: with branch_taken=1 in cycle t, imem_addr=branch_target in t+1 with ID_valid=0. The target instruction is in ID at t+2.
- halted is registered: it asserts in the cycle after the HALT instruction leaves ID.
- A reset asserted mid-stall, mid-branch, or while HALTED takes effect at the next edge with the reset values above.

## Test plan
- Reset, then free-run with PCwrite=IF_IDwrite=1 and imem_data=address-tagged words → imem_addr 0,1,2,…; ID_instr lags by one cycle; ID_pc_plus1=addr+1; fetch_count increments every cycle.
- With PC=5, hold PCwrite=IF_IDwrite=0 for 2 cycles → imem_addr stays 5 and ID_instr/ID_pc_plus1 are unchanged; fetch continues at 6 after release.
- At PC=9 assert branch_taken=1, branch_target=0x40, and PCwrite=IF_IDwrite=0 in the same cycle → next cycle imem_addr=0x40 and ID_valid=0; the following cycle ID_instr=mem[0x40].
- Place HALT (instr[18:14]=5'h1F) at address 3 → it enters ID at cycle 4 and halted=1 at cycle 5. After that, ID_valid=0, imem_addr is frozen, and toggling branch_taken has no effect.
- HALT in ID with IF_IDwrite=0 → no halt. When IF_IDwrite returns to 1, the halt happens on that edge. HALT in ID with branch_taken=1 → no halt; the PC is redirected instead.
- With ADDR_W=4, run from PC=14 → 14,15,0 wrap. Force fetch_count to 16'hFFFF (long run or preload) → it stays at 16'hFFFF. Assert rst while HALTED → all outputs return to reset values.
